// File: rtl/btn_event_queue.sv
// btn_event_queue: collects one-cycle press pulses from the per-button
// debouncers. Each pulse becomes a button index in a small show-ahead FIFO.
// Simultaneous presses are serialized lowest index first. One press per button
// can wait in a pending register while the FIFO is full. A second press on a
// button that is still pending is lost, and that sets the sticky overflow flag.
//
// Optional feature (macro BTN_EVT_TIMESTAMP_EN): a 16-bit free-running cycle
// counter is sampled when a pulse sets its pending bit. That stamp is stored
// with the event and shown on evt_time for the head entry (0 when empty).
module btn_event_queue #(
    parameter int N_BTN = 4,
    parameter int DEPTH = 8,
    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic             rd_en,
    input  logic             clr_overflow,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_code,
    output logic [CNT_W-1:0] evt_count,
`ifdef BTN_EVT_TIMESTAMP_EN
    output logic [15:0]      evt_time,
`endif
    output logic             overflow
);

    localparam int AW = CNT_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [N_BTN-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [IDX_W-1:0] enq_idx;
    logic [N_BTN-1:0] enq_mask;
    logic [N_BTN-1:0] lost;
    logic             pop;
    logic             can_accept;
    logic             push;

    // Pop only when something is queued. The FIFO accepts when it is not full,
    // or when it is full and a pop frees the slot on the same edge.
    assign pop        = rd_en && (count_q != '0);
    assign can_accept = (count_q < DEPTH_C) || ((count_q == DEPTH_C) && rd_en);
    assign push       = (|pending_q) && can_accept;

    // Priority encoder: the lowest set pending bit wins the enqueue slot.
    always_comb begin
        enq_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                enq_idx = IDX_W'(i);
            end
        end
    end

    // Pending/overflow next state. A pulse on the button being enqueued this
    // cycle is a new, separate event. A pulse on a button that stays pending
    // is lost.
    always_comb begin
        enq_mask = '0;
        for (int i = 0; i < N_BTN; i++) begin
            enq_mask[i] = push && (enq_idx == IDX_W'(i));
        end
        lost      = btn_pulse & pending_q & ~enq_mask;
        pending_d = (pending_q & ~enq_mask) | btn_pulse;
        if (|lost) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Occupancy changes only when exactly one of push and pop happens.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers: pending bits, FIFO storage, wrapping pointers and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                mem_q[wr_ptr_q] <= enq_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef BTN_EVT_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] stamp_q [N_BTN];
    logic [15:0] tmem_q  [DEPTH];

    // A stamp is taken when a pulse sets pending. A lost press keeps the stamp
    // of the press that is still waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                stamp_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                tmem_q[i] <= '0;
            end
        end else begin
            ts_q <= ts_q + 16'd1;
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_pulse[i] && !lost[i]) begin
                    stamp_q[i] <= ts_q;
                end
            end
            if (push) begin
                tmem_q[wr_ptr_q] <= stamp_q[enq_idx];
            end
        end
    end

    assign evt_time = evt_valid ? tmem_q[rd_ptr_q] : 16'h0000;
`endif

    assign evt_valid = (count_q != '0);
    assign evt_code  = mem_q[rd_ptr_q];
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue with N_BTN=4, DEPTH=4. Inputs change 1ns
// after each rising edge. Outputs are sampled at that same point, before the
// next inputs are applied.
module tb_btn_event_queue;

    localparam int N_BTN = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [3:0] btn_pulse;
    logic       rd_en;
    logic       clr_overflow;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [2:0] evt_count;
    logic       overflow;
`ifdef BTN_EVT_TIMESTAMP_EN
    logic [15:0] evt_time;
`endif

    int checks   = 0;
    int failures = 0;

    btn_event_queue #(.N_BTN(N_BTN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_pulse    (btn_pulse),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_count    (evt_count),
`ifdef BTN_EVT_TIMESTAMP_EN
        .evt_time     (evt_time),
`endif
        .overflow     (overflow)
    );

    // 10ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] c, input logic [2:0] n);
        check({tag, ".valid"}, 32'(evt_valid), 32'(v));
        if (v) check({tag, ".code"}, 32'(evt_code), 32'(c));
        check({tag, ".count"}, 32'(evt_count), 32'(n));
    endtask

    logic [1:0] wrap_codes [10];

    initial begin
        wrap_codes = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
        reset        = 1'b1;
        btn_pulse    = '0;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst.valid", 32'(evt_valid), 0);
        check("rst.code", 32'(evt_code), 0);
        check("rst.count", 32'(evt_count), 0);
        check("rst.ovf", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single press: pending at edge k, queued at edge k+1
        btn_pulse = 4'b0100;
        tick();
        btn_pulse = '0;
        check_out("single.k", 1'b0, 2'd0, 3'd0);
        tick();
        check_out("single.k1", 1'b1, 2'd2, 3'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_out("single.pop", 1'b0, 2'd0, 3'd0);

        // Simultaneous press 1011 -> codes 0,1,3 over three edges
        btn_pulse = 4'b1011;
        tick();
        btn_pulse = '0;
        tick();
        check_out("simul.e1", 1'b1, 2'd0, 3'd1);
        tick();
        check_out("simul.e2", 1'b1, 2'd0, 3'd2);
        tick();
        check_out("simul.e3", 1'b1, 2'd0, 3'd3);
        tick();
        check_out("simul.idle", 1'b1, 2'd0, 3'd3);
        rd_en = 1'b1;
        tick();
        check_out("simul.pop1", 1'b1, 2'd1, 3'd2);
        tick();
        check_out("simul.pop2", 1'b1, 2'd3, 3'd1);
        tick();
        rd_en = 1'b0;
        check_out("simul.pop3", 1'b0, 2'd0, 3'd0);
        check("simul.ovf", 32'(overflow), 0);

        // Full FIFO with button 2 held pending
        btn_pulse = 4'b1111;
        tick();
        btn_pulse = '0;
        tick();
        tick();
        tick();
        tick();
        check_out("full.fill", 1'b1, 2'd0, 3'd4);
        btn_pulse = 4'b0100;
        tick();
        btn_pulse = '0;
        tick();
        check_out("full.hold", 1'b1, 2'd0, 3'd4);
        tick();
        check_out("full.hold2", 1'b1, 2'd0, 3'd4);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_out("full.poppush", 1'b1, 2'd1, 3'd4);
        tick();
        check_out("full.settle", 1'b1, 2'd1, 3'd4);

        // Overflow while full: queue is 1,2,3,2
        btn_pulse = 4'b0010;
        tick();
        btn_pulse = '0;
        check("ovf.first", 32'(overflow), 0);
        btn_pulse = 4'b0010;
        tick();
        btn_pulse = '0;
        check("ovf.second", 32'(overflow), 1);
        tick();
        check("ovf.sticky", 32'(overflow), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf.clr", 32'(overflow), 0);
        clr_overflow = 1'b1;
        btn_pulse    = 4'b0010;
        tick();
        clr_overflow = 1'b0;
        btn_pulse    = '0;
        check("ovf.set_wins", 32'(overflow), 1);
        check_out("ovf.count", 1'b1, 2'd1, 3'd4);

        // Drain: pop 1 frees a slot for pending button 1 on the same edge
        rd_en = 1'b1;
        tick();
        check_out("drain.1", 1'b1, 2'd2, 3'd4);
        tick();
        check_out("drain.2", 1'b1, 2'd3, 3'd3);
        tick();
        check_out("drain.3", 1'b1, 2'd2, 3'd2);
        tick();
        check_out("drain.4", 1'b1, 2'd1, 3'd1);
        tick();
        check_out("drain.5", 1'b0, 2'd0, 3'd0);
        rd_en = 1'b0;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("drain.ovf_clr", 32'(overflow), 0);

        // Empty read is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_out("empty.rd", 1'b0, 2'd0, 3'd0);
        tick();
        check_out("empty.after", 1'b0, 2'd0, 3'd0);

        // Ten push/pop pairs: pointers wrap past DEPTH
        for (int i = 0; i < 10; i++) begin
            btn_pulse = 4'b0001 << wrap_codes[i];
            tick();
            btn_pulse = '0;
            tick();
            check_out($sformatf("wrap.push%0d", i), 1'b1, wrap_codes[i], 3'd1);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            check_out($sformatf("wrap.pop%0d", i), 1'b0, 2'd0, 3'd0);
        end

        // Reset mid-operation: 3 queued (0,1,2) and 2 pending (0,3)
        btn_pulse = 4'b0111;
        tick();
        btn_pulse = '0;
        tick();
        tick();
        btn_pulse = 4'b1001;
        tick();
        btn_pulse = '0;
        check_out("mid.pre", 1'b1, 2'd0, 3'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mid.valid", 32'(evt_valid), 0);
        check("mid.code", 32'(evt_code), 0);
        check("mid.count", 32'(evt_count), 0);
        check("mid.ovf", 32'(overflow), 0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        check_out("mid.discard", 1'b0, 2'd0, 3'd0);
        btn_pulse = 4'b1000;
        tick();
        btn_pulse = '0;
        check_out("mid.press.k", 1'b0, 2'd0, 3'd0);
        tick();
        check_out("mid.press.k1", 1'b1, 2'd3, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_event_queue.md
Name: btn_event_queue

Overview:
- Sits directly downstream of the per-button debouncers.
- Collects their one-cycle press pulses, encodes each pulse as a button index, and buffers the indices in a small show-ahead FIFO.
- The processor/game FSM pops events at its own pace, so no press is lost while the consumer is busy.
- Simultaneous presses are serialized, lowest index first.

Parameters:
- N_BTN, 4, number of debounced button pulse inputs (2..16)
- DEPTH, 8, FIFO entries (power of two, ≥2)
- IDX_W, derived localparam = max(1, clog2(N_BTN)), width of an event code

Ports:
- clk  in  1  system clock, same clock that drives the debouncers
- reset  in  1  asynchronous, active-high; clears all state
- btn_pulse  in  N_BTN  one-cycle press pulses, bit i = button i
- rd_en  in  1  consumer pops the head entry this cycle
- clr_overflow  in  1  clears the sticky overflow flag
- evt_valid  out  1  FIFO non-empty; head entry is valid
- evt_code  out  IDX_W  button index of the head entry
- evt_count  out  clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a press was lost

Behaviour:
- Reset (async assert, sync release): pending = 0, FIFO pointers = 0, evt_valid = 0, evt_code = 0, evt_count = 0, overflow = 0.
  - Reset mid-operation discards all pending and queued events.
- Pending register, one bit per button:
  - btn_pulse[i] = 1 at edge k sets pending[i].
  - pending[i] clears when button i is enqueued.
  - Pulse in the same cycle its pending bit is enqueued: pending[i] stays 1 (new, separate event).
- Enqueue arbiter:
  - Each edge, if pending ≠ 0 and the FIFO can accept, write the lowest-index set pending bit into the tail.
  - At most one enqueue per cycle.
  - Can accept = evt_count < DEPTH, or (evt_count == DEPTH and rd_en = 1); pop and push in the same cycle when full is legal.
- Latency: pulse sampled at edge k → pending at k → enqueued at k+1 → evt_valid = 1 and evt_code valid after edge k+1 (2 cycles, FIFO empty, no contention).
- Read (show-ahead):
  - evt_valid = (evt_count ≠ 0).
  - evt_code always reflects the head entry.
  - rd_en with evt_valid = 1 pops at the edge.
  - rd_en with evt_valid = 0 is ignored: no pointer change, no flag.
- Simultaneous push and pop: evt_count unchanged; pointers both advance, wrapping modulo DEPTH.
- FIFO full:
  - Pending bits hold; they are not dropped.
  - Enqueue resumes the cycle after space is available, or in the same cycle as a pop.
- Overflow:
  - Set when btn_pulse[i] = 1 while pending[i] = 1 and button i is not being enqueued that cycle; the second press is lost.
  - Sticky.
  - clr_overflow clears it at the edge; a set in the same cycle wins over a clear.
- evt_count is a registered occupancy: +1 on push only, −1 on pop only, unchanged for both or neither.
- No combinational path from btn_pulse to any output; all outputs are registered or derived from registers/RAM read.

Optional Feature:
- Macro: BTN_EVT_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter, reset to 0, wrapping at 0xFFFF.
  - Adds output evt_time [15:0].
  - Each entry stores the counter value at the edge the pulse set its pending bit, captured per button alongside pending.
  - evt_time shows the head entry's stamp; 0 when empty.
- Not defined: no counter, no evt_time port, FIFO entries are IDX_W bits only.

Test Plan (N_BTN=4, DEPTH=4):
- Single press: btn_pulse=4'b0100 at edge 10, rd_en=0 → evt_valid=1, evt_code=2, evt_count=1 after edge 11; rd_en=1 for one cycle → evt_valid=0, evt_count=0.
- Simultaneous press: btn_pulse=4'b1011 at one edge → codes 0, 1, 3 enqueued on three consecutive edges; pops return 0, 1, 3 in order; overflow=0.
- Full FIFO: 4 events queued and a fifth pending (button 2) → evt_count holds at 4 and pending[2] remains. Then:
  - One rd_en → pop and push in the same edge, count stays 4.
  - Button 2 appears as the last entry.
- Overflow: pulse button 1 twice while the FIFO is full → overflow=1 after the second pulse. Then:
  - clr_overflow=1 → overflow=0 next edge.
  - clr_overflow together with a new lost pulse → overflow stays 1.
- Empty read and wrap: rd_en=1 with FIFO empty → no change. Then push/pop 10 events → pointers wrap and codes match input order.
- Reset mid-operation: assert reset asynchronously with 3 queued and 2 pending → all outputs 0 immediately. After release, a press → evt_valid after 2 cycles.
